multicycle_ctrl_unit: RTL
=========================

Name: multicycle_ctrl_unit

Overview:
- Control FSM for the multi-cycle processor.
- Drives the ALU's 4-bit operation select and carry-in, and consumes the ALU's N/Z/C/V flags.
- Owns the architectural NZCV register, evaluates ARM condition codes, and sequences fetch/decode/execute/memory/writeback.
- Sits between the instruction register and the datapath muxes/enables.

Parameters:
- RESET_FLAGS, 4'b0000, NZCV value loaded on reset.
- FETCH_INC, 4, constant PC increment selected on src_b=2 during FETCH (informational; the datapath supplies the constant).

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- instr  in  32  current instruction register contents
- alu_negative_flag / alu_zero_flag / alu_carry_out_flag / alu_overflow_flag  in  1 each  ALU flag outputs
- out_operation_select  out  4  ALU operation code
- out_alu_carry  out  1  stored C flag, fed to ALU carry input
- out_alu_src_a  out  1  0=PC, 1=register A
- out_alu_src_b  out  2  0=register B, 1=extended immediate, 2=constant 4
- out_adr_src  out  1  memory address: 0=PC, 1=ALU-out register
- out_result_src  out  2  0=ALU out register, 1=memory data register, 2=live ALU result
- out_ir_write, out_pc_write, out_mem_write, out_reg_write  out  1 each  write enables
- out_flags  out  4  NZCV register
- out_state  out  4  current state (debug)

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=FETCH, flags=RESET_FLAGS.
  - All write enables are 0 while reset_n is low; they resume on the first clk edge after release.
  - Reset mid-instruction abandons the instruction; no partial writes after reset asserts.
- Instruction fields: cond=instr[31:28], op=instr[27:26], I=instr[25], cmd=instr[24:21], S=instr[20], L=instr[20] (memory).
- States and transitions:
  - FETCH: adr_src=0, ir_write=1, src_a=0, src_b=2, op=0100, result_src=2, pc_write=1 -> DECODE.
  - DECODE: evaluate cond against the registered flags.
    - cond fails -> FETCH, no writes.
    - op=00 -> EXEC_DP.
    - op=01 -> MEM_ADR.
    - op=10 -> BRANCH.
    - op=11 -> FETCH (undefined; treat as NOP).
  - EXEC_DP: src_a=1, src_b = I ? 1 : 0, op = mapped cmd.
    - Flags latch at end of cycle if S=1 or cmd is TST/TEQ/CMP/CMN.
    - -> ALU_WB, or -> FETCH for the four compare commands.
  - ALU_WB: result_src=0, reg_write=1 -> FETCH.
  - MEM_ADR: src_a=1, src_b=1, op=0100 -> MEM_RD if L=1, else MEM_WR.
  - MEM_RD: adr_src=1 -> MEM_WB.
  - MEM_WB: result_src=1, reg_write=1 -> FETCH.
  - MEM_WR: adr_src=1, mem_write=1 -> FETCH.
  - BRANCH: src_a=0, src_b=1, op=0100, result_src=2, pc_write=1 -> FETCH.
- cmd mapping:
  - TST(1000) -> 0000, TEQ(1001) -> 0001, CMP(1010) -> 0010, CMN(1011) -> 0100.
  - All other cmd values pass through unchanged.
  - In non-DP states, unused op outputs drive 0100.
- Flag update:
  - NZCV <= {alu_negative_flag, alu_zero_flag, alu_carry_out_flag, alu_overflow_flag}.
  - For logical cmds (0000, 0001, 1000, 1001, 1100, 1101, 1110, 1111), C and V hold their old values; only N and Z update.
- Carry input: out_alu_carry = flags[C] always (registered value, not the live ALU flag).
- Condition codes: standard ARM set.
  - EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL.
  - 1111 is treated as AL.
  - Evaluation is combinational from registered flags in DECODE.
- Latency:
  - DP instruction with writeback: 4 cycles.
  - Compare: 3 cycles.
  - LDR: 5 cycles.
  - STR: 4 cycles.
  - Branch: 3 cycles.
  - Failed condition: 2 cycles.
- Outputs are Moore (function of state and instr only), except flag latching.

Decomposition:
- Shared package ctrl_pkg holds:
  - state encodings (4-bit);
  - ALU op constants, identical values to the ALU's operation encodings;
  - cond-code constants;
  - src mux select constants.
- One sub-module, cond_check: inputs cond[3:0] and flags[3:0], output pass. Purely combinational.

Test Plan:
- Reset held, then released -> state=FETCH, flags=0000, first cycle shows ir_write=pc_write=1, op=0100, src_b=2.
- ADDS R,R,#imm with ALU flags N0 Z0 C1 V0 in EXEC_DP -> op=0100, src_b=1, flags become 0010, reg_write=1 in next cycle, back in FETCH after 4 cycles.
- CMP (cmd 1010) with ALU Z=1, C=1 -> op=0010, flags=0110, no reg_write, FETCH after 3 cycles; a following BEQ (cond 0000) takes BRANCH with pc_write=1.
- BNE (cond 0001) with flags Z=1 -> DECODE returns to FETCH, no pc_write/reg_write/mem_write pulses.
- ANDS with flags previously 0011 and ALU C=0, V=0, result zero -> flags become 0111 (C/V held); ADC then shows out_alu_carry=1.
- LDR -> state sequence FETCH, DECODE, MEM_ADR, MEM_RD, MEM_WB, with adr_src=1 in MEM_RD and result_src=1 in MEM_WB. Separately, drop reset_n in MEM_RD -> immediate FETCH, no reg_write.

Source files
------------

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the multi-cycle control unit.
//   - FSM state encodings (4-bit, visible on out_state)
//   - ALU operation codes (same values the ALU decodes)
//   - data-processing command and condition-code constants
//   - datapath mux select constants
//   - helpers that classify and remap data-processing commands
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_EXEC_DP = 4'd2,
    S_ALU_WB  = 4'd3,
    S_MEM_ADR = 4'd4,
    S_MEM_RD  = 4'd5,
    S_MEM_WB  = 4'd6,
    S_MEM_WR  = 4'd7,
    S_BRANCH  = 4'd8
  } state_t;

  // ALU operation encodings
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_EOR = 4'b0001;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_ADD = 4'b0100;

  // Data-processing commands that need remapping
  localparam logic [3:0] CMD_TST = 4'b1000;
  localparam logic [3:0] CMD_TEQ = 4'b1001;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_CMN = 4'b1011;

  // Condition codes
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  // Mux selects
  localparam logic       SRCA_PC     = 1'b0;
  localparam logic       SRCA_REG    = 1'b1;
  localparam logic [1:0] SRCB_REG    = 2'd0;
  localparam logic [1:0] SRCB_IMM    = 2'd1;
  localparam logic [1:0] SRCB_FOUR   = 2'd2;
  localparam logic       ADR_PC      = 1'b0;
  localparam logic       ADR_ALUOUT  = 1'b1;
  localparam logic [1:0] RES_ALUOUT  = 2'd0;
  localparam logic [1:0] RES_MEMDATA = 2'd1;
  localparam logic [1:0] RES_ALU     = 2'd2;

  // Compare commands write flags only, never a register.
  function automatic logic is_compare(input logic [3:0] cmd);
    return (cmd == CMD_TST) || (cmd == CMD_TEQ) ||
           (cmd == CMD_CMP) || (cmd == CMD_CMN);
  endfunction

  // Logical commands leave C and V untouched when flags update.
  function automatic logic is_logical(input logic [3:0] cmd);
    return (cmd == 4'b0000) || (cmd == 4'b0001) ||
           (cmd[3:1] == 3'b100) || (cmd[3:2] == 2'b11);
  endfunction

  // Compares reuse the ALU's arithmetic/logic op without writeback.
  function automatic logic [3:0] map_cmd(input logic [3:0] cmd);
    case (cmd)
      CMD_TST: return ALU_AND;
      CMD_TEQ: return ALU_EOR;
      CMD_CMP: return ALU_SUB;
      CMD_CMN: return ALU_ADD;
      default: return cmd;
    endcase
  endfunction

endpackage

// File: rtl/cond_check.sv
// cond_check: combinational ARM condition-code evaluation.
//   i cond[3:0]  : instruction condition field
//   i flags[3:0] : NZCV register
//   o pass       : 1 when the instruction should execute
module cond_check
  import ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic w_n, w_z, w_c, w_v;
  assign {w_n, w_z, w_c, w_v} = flags;

  always_comb begin
    pass = 1'b1;
    case (cond)
      COND_EQ: pass = w_z;
      COND_NE: pass = ~w_z;
      COND_CS: pass = w_c;
      COND_CC: pass = ~w_c;
      COND_MI: pass = w_n;
      COND_PL: pass = ~w_n;
      COND_VS: pass = w_v;
      COND_VC: pass = ~w_v;
      COND_HI: pass = w_c & ~w_z;
      COND_LS: pass = ~w_c | w_z;
      COND_GE: pass = (w_n == w_v);
      COND_LT: pass = (w_n != w_v);
      COND_GT: pass = ~w_z & (w_n == w_v);
      COND_LE: pass = w_z | (w_n != w_v);
      default: pass = 1'b1;  // AL, and 1111 behaves as AL
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_unit.sv
// multicycle_ctrl_unit: control FSM of the multi-cycle processor.
//   i clk, reset_n (async, active-low)
//   i instr[31:0]           : instruction register contents
//   i alu_*_flag            : ALU N/Z/C/V outputs
//   o out_operation_select  : ALU op code
//   o out_alu_carry         : registered C flag into the ALU
//   o out_alu_src_a/_b      : ALU operand muxes
//   o out_adr_src           : memory address mux
//   o out_result_src        : result mux
//   o out_ir/pc/mem/reg_write : write enables (forced low during reset)
//   o out_flags             : NZCV register
//   o out_state             : current FSM state
module multicycle_ctrl_unit #(
  parameter logic [3:0] RESET_FLAGS = 4'b0000,
  parameter int         FETCH_INC   = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] instr,
  input  logic        alu_negative_flag,
  input  logic        alu_zero_flag,
  input  logic        alu_carry_out_flag,
  input  logic        alu_overflow_flag,
  output logic [3:0]  out_operation_select,
  output logic        out_alu_carry,
  output logic        out_alu_src_a,
  output logic [1:0]  out_alu_src_b,
  output logic        out_adr_src,
  output logic [1:0]  out_result_src,
  output logic        out_ir_write,
  output logic        out_pc_write,
  output logic        out_mem_write,
  output logic        out_reg_write,
  output logic [3:0]  out_flags,
  output logic [3:0]  out_state
);
  import ctrl_pkg::*;

  // The datapath hard-wires the src_b=2 constant; it must match this.
  if (FETCH_INC != 4) begin : g_bad_fetch_inc
    $error("FETCH_INC must be 4");
  end

  state_t     r_state;
  logic [3:0] r_flags;

  logic [3:0] w_cond, w_cmd;
  logic [1:0] w_op;
  logic       w_imm, w_s_bit, w_cond_pass;
  logic       w_ir_write, w_pc_write, w_mem_write, w_reg_write;
  logic       w_unused_ok;

  assign w_cond      = instr[31:28];
  assign w_op        = instr[27:26];
  assign w_imm       = instr[25];
  assign w_cmd       = instr[24:21];
  assign w_s_bit     = instr[20];  // also L for memory instructions
  assign w_unused_ok = &{1'b0, instr[19:0]};

  cond_check u_cond_check (
    .cond  (w_cond),
    .flags (r_flags),
    .pass  (w_cond_pass)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_FETCH;
      r_flags <= RESET_FLAGS;
    end else begin
      if (r_state == S_EXEC_DP && (w_s_bit || is_compare(w_cmd))) begin
        r_flags[3:2] <= {alu_negative_flag, alu_zero_flag};
        if (!is_logical(w_cmd))
          r_flags[1:0] <= {alu_carry_out_flag, alu_overflow_flag};
      end
      case (r_state)
        S_FETCH:  r_state <= S_DECODE;
        S_DECODE: begin
          if (!w_cond_pass)      r_state <= S_FETCH;
          else if (w_op == 2'b00) r_state <= S_EXEC_DP;
          else if (w_op == 2'b01) r_state <= S_MEM_ADR;
          else if (w_op == 2'b10) r_state <= S_BRANCH;
          else                    r_state <= S_FETCH;
        end
        S_EXEC_DP: r_state <= is_compare(w_cmd) ? S_FETCH : S_ALU_WB;
        S_MEM_ADR: r_state <= w_s_bit ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD:  r_state <= S_MEM_WB;
        default:   r_state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    out_operation_select = ALU_ADD;
    out_alu_src_a        = SRCA_PC;
    out_alu_src_b        = SRCB_REG;
    out_adr_src          = ADR_PC;
    out_result_src       = RES_ALUOUT;
    w_ir_write           = 1'b0;
    w_pc_write           = 1'b0;
    w_mem_write          = 1'b0;
    w_reg_write          = 1'b0;
    case (r_state)
      S_FETCH: begin
        out_alu_src_b  = SRCB_FOUR;
        out_result_src = RES_ALU;
        w_ir_write     = 1'b1;
        w_pc_write     = 1'b1;
      end
      S_EXEC_DP: begin
        out_alu_src_a        = SRCA_REG;
        out_alu_src_b        = w_imm ? SRCB_IMM : SRCB_REG;
        out_operation_select = map_cmd(w_cmd);
      end
      S_ALU_WB: w_reg_write = 1'b1;
      S_MEM_ADR: begin
        out_alu_src_a = SRCA_REG;
        out_alu_src_b = SRCB_IMM;
      end
      S_MEM_RD: out_adr_src = ADR_ALUOUT;
      S_MEM_WB: begin
        out_result_src = RES_MEMDATA;
        w_reg_write    = 1'b1;
      end
      S_MEM_WR: begin
        out_adr_src = ADR_ALUOUT;
        w_mem_write = 1'b1;
      end
      S_BRANCH: begin
        out_alu_src_b  = SRCB_IMM;
        out_result_src = RES_ALU;
        w_pc_write     = 1'b1;
      end
      default: ;
    endcase
  end

  // Enables are gated directly by reset_n so nothing is written while
  // reset is held, even in the cycle where it asserts.
  assign out_ir_write  = w_ir_write  & reset_n;
  assign out_pc_write  = w_pc_write  & reset_n;
  assign out_mem_write = w_mem_write & reset_n;
  assign out_reg_write = w_reg_write & reset_n;

  assign out_flags     = r_flags;
  assign out_alu_carry = r_flags[1];
  assign out_state     = r_state;

endmodule
